// File: rtl/alu_seq.sv
// alu_seq: single-issue sequential ALU with a valid/ready handshake on both sides.
//   Logic, add, subtract and signed set-less-than complete in one cycle. Unsigned
//   multiply runs one shift-add iteration per cycle for WIDTH cycles. The result is
//   held in DONE until the consumer takes it.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operation presented; accepted when in_ready is also high
//   in_ready   high only in IDLE
//   a, b, op   operands and operation code, captured on the accepting edge
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer takes the result this cycle
//   result     low WIDTH bits of the result
//   result_hi  high WIDTH bits of the product (MUL only, else 0)
//   cout       carry out of the MSB (ADD/SUB/SLT)
//   overflow   signed overflow (ADD/SUB/SLT)
//   zero       result (or full product for MUL) is zero
//   busy       high while a multiply is running or a result is pending
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpMul  = 3'b011;
  localparam logic [2:0] OpAndn = 3'b100;
  localparam logic [2:0] OpOrn  = 3'b101;
  localparam logic [2:0] OpSub  = 3'b110;
  localparam logic [2:0] OpSlt  = 3'b111;

  logic [1:0]         r_state;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_cout;
  logic               r_overflow;
  logic               r_zero;
  logic               r_busy;

  // Single-cycle datapath. op[2] selects ~b for ANDN/ORN/SUB/SLT; only SUB and SLT
  // also add the carry-in that completes the two's-complement negation.
  logic [WIDTH-1:0]   w_b_op;
  logic               w_sub;
  logic [WIDTH:0]     w_sum_full;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic               w_carry_msb_in;
  logic               w_add_ovf;
  logic [WIDTH-1:0]   w_res;
  logic               w_cout;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_b_op     = op[2] ? ~b : b;
  assign w_sub      = (op == OpSub) || (op == OpSlt);
  assign w_sum_full = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
  assign w_sum      = w_sum_full[WIDTH-1:0];
  assign w_carry    = w_sum_full[WIDTH];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered by XOR.
  assign w_carry_msb_in = a[WIDTH-1] ^ w_b_op[WIDTH-1] ^ w_sum[WIDTH-1];
  assign w_add_ovf      = w_carry_msb_in ^ w_carry;

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (op)
      OpAnd, OpAndn: w_res = a & w_b_op;
      OpOr, OpOrn:   w_res = a | w_b_op;
      OpAdd, OpSub: begin
        w_res  = w_sum;
        w_cout = w_carry;
        w_ovf  = w_add_ovf;
      end
      OpSlt: begin
        w_res  = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
        w_cout = w_carry;
        w_ovf  = w_add_ovf;
      end
      default: w_res = '0;  // MUL result comes from the iterative path
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier
  // LSB is set.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_busy <= 1'b1;
            if (op == OpMul) begin
              r_state  <= StMul;
              r_cnt    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_acc    <= '0;
            end else begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_result_hi <= '0;
              r_cout      <= w_cout;
              r_overflow  <= w_ovf;
              r_zero      <= (w_res == '0);
            end
          end
        end
        StMul: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LastIter) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next[WIDTH-1:0];
            r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= (w_acc_next == '0);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH = 8. Directed table of known
//   vectors, hand-written reset/backpressure sequences, then random operations checked
//   against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  vec_t tbl [0:14];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions, using signed/unsigned integers.
  task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output vec_t v);
    int ux, uy, sx, sy, s, sr, p;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    v = '0;
    v.op = o;
    v.a  = x;
    v.b  = y;
    case (o)
      3'b000: v.res = x & y;
      3'b001: v.res = x | y;
      3'b100: v.res = x & ~y;
      3'b101: v.res = x | ~y;
      3'b010: begin
        s      = ux + uy;
        sr     = sx + sy;
        v.res  = 8'(s);
        v.cout = (s > 255);
        v.ovf  = (sr > 127) || (sr < -128);
      end
      3'b110, 3'b111: begin
        s      = ux + (255 - uy) + 1;
        sr     = sx - sy;
        v.cout = (s > 255);
        v.ovf  = (sr > 127) || (sr < -128);
        v.res  = (o == 3'b110) ? 8'(s) : ((sx < sy) ? 8'd1 : 8'd0);
      end
      default: begin
        p    = ux * uy;
        v.hi = 8'(p >> 8);
        v.res = 8'(p);
      end
    endcase
    v.zero = (v.res == 8'd0) && (v.hi == 8'd0);
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " result"}, result, v.res);
    chk({tag, " result_hi"}, result_hi, v.hi);
    chk({tag, " cout"}, cout, v.cout);
    chk({tag, " overflow"}, overflow, v.ovf);
    chk({tag, " zero"}, zero, v.zero);
  endtask

  // One full transaction: present at a negedge, count cycles to out_valid, check the
  // result, hold it under backpressure for 'hold' cycles, then hand it off.
  task automatic run_op(input string tag, input vec_t v, input int hold);
    int cyc;
    int exp_lat;
    bit bad_ctl;
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1'b1);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    op = v.op;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    op = 3'($urandom);
    cyc = 1;
    bad_ctl = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready || !busy) bad_ctl = 1'b1;
      in_valid = 1'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cyc++;
    end
    exp_lat = (v.op == 3'b011) ? W + 1 : 1;
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " ctl while mul"}, bad_ctl, 1'b0);
    chk({tag, " out_valid"}, out_valid, 1'b1);
    chk({tag, " in_ready done"}, in_ready, 1'b0);
    chk({tag, " busy done"}, busy, 1'b1);
    chk_outs(tag, v);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      op = 3'($urandom);
      @(negedge clk);
      chk({tag, " held out_valid"}, out_valid, 1'b1);
      chk({tag, " held in_ready"}, in_ready, 1'b0);
      chk({tag, " held result"}, {result_hi, result, cout, overflow, zero},
          {v.hi, v.res, v.cout, v.ovf, v.zero});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after handoff"}, out_valid, 1'b0);
    chk({tag, " in_ready after handoff"}, in_ready, 1'b1);
    chk({tag, " busy after handoff"}, busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    int cyc;
    bit saw_valid;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    //           op      a      b      res    hi     c     v     z
    tbl[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{3'b010, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{3'b110, 8'hF9, 8'hF9, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{3'b111, 8'hF9, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'b111, 8'hFF, 8'hF9, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{3'b111, 8'hFF, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{3'b100, 8'hFF, 8'h02, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'b000, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{3'b001, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'b101, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{3'b110, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'b110, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{3'b011, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3'b011, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{3'b011, 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset outputs", {result_hi, result, cout, overflow, zero, busy}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1'b1);
    chk("post-reset busy", busy, 1'b0);

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i], (i == 0 || i == 12) ? 3 : 0);
    end

    // Reset four cycles into a multiply, with an accept attempt during reset.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    op = 3'b011;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mul busy before abort", busy, 1'b1);
    reset = 1'b1;
    in_valid = 1'b1;
    op = 3'b010;
    a = 8'h12;
    b = 8'h34;
    @(negedge clk);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort outputs", {result_hi, result, cout, overflow, zero, busy}, '0);
    chk("abort in_ready", in_ready, 1'b1);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort in_ready after deassert", in_ready, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || busy) saw_valid = 1'b1;
      @(negedge clk);
    end
    chk("abort no stray result", saw_valid, 1'b0);

    // Random operations against the model, with random backpressure.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h80;
      model(rop, ra, rb, v);
      run_op($sformatf("rnd%0d op%0d a%0h b%0h", i, rop, ra, rb), v, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/op presented this cycle.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation code (REQ-012).
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result/result_hi  output  WIDTH each; cout, overflow, zero, busy  output  1 each; all registered.

Function
REQ-012 op: 000 AND; 001 OR; 100 AND ~b; 101 OR ~b; 010 ADD; 110 SUB (a + ~b + 1); 111 SLT signed; 011 MUL unsigned.
REQ-013 FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE; busy = 1 in MUL and DONE.
REQ-014 Accept = in_valid & in_ready at a rising edge; a, b, op captured on that edge.
REQ-015 Non-MUL accept: IDLE -> DONE on the accepting edge; out_valid high the very next cycle (latency 1).
REQ-016 MUL accept: IDLE -> MUL, iteration counter = 0; one shift-add iteration per cycle; after WIDTH iterations -> DONE; out_valid high WIDTH+1 cycles after accept.
REQ-017 DONE: result, flags, out_valid held stable until out_ready = 1; DONE & out_ready -> IDLE, out_valid low next cycle.
REQ-018 No new accept while in DONE; earliest next accept is the cycle after the out_ready handshake.
REQ-019 in_valid in MUL/DONE is ignored; a, b, op changes after accept do not affect the result in flight.
REQ-020 ADD/SUB: result = low WIDTH bits of sum; cout = carry out of MSB; overflow = carry into MSB XOR carry out of MSB.
REQ-021 SLT: internal SUB; result = 1 (zero-extended) if (sum MSB XOR overflow) = 1, else 0; cout, overflow reported from the SUB.
REQ-022 Logic ops: cout = 0, overflow = 0.
REQ-023 MUL: {result_hi, result} = unsigned 2*WIDTH-bit product; cout = 0, overflow = 0.
REQ-024 result_hi = 0 for every non-MUL op.
REQ-025 zero = 1 iff result == 0 (non-MUL) or {result_hi, result} == 0 (MUL).
REQ-026 Outputs change only on transitions into DONE or reset; no combinational path from a/b/op to outputs.

Reset
REQ-027 reset sampled high: state -> IDLE; out_valid = 0; result, result_hi = 0; cout, overflow, zero = 0; busy = 0; counter = 0.
REQ-028 in_ready = 1 the first cycle after reset deasserts.
REQ-029 Reset in MUL or DONE aborts the operation; no out_valid is produced for it.
REQ-030 Reset has priority over accept and out_ready in the same cycle.

Verification (WIDTH = 8)
REQ-031 ADD a=0x7F b=0x01 -> out_valid next cycle, result 0x80, overflow 1, cout 0, zero 0.
REQ-032 ADD a=0x80 b=0x80 -> result 0x00, cout 1, overflow 1, zero 1; SUB a=0xF9 b=0xF9 -> result 0x00, cout 1, overflow 0, zero 1.
REQ-033 SLT a=0xF9 b=0xFF -> result 0x01; SLT a=0xFF b=0xF9 -> 0x00; SLT a=0xFF b=0x00 -> 0x01; AND ~b a=0xFF b=0x02 -> 0xFD.
REQ-034 MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result_hi 0xFE, result 0x01, zero 0; in_ready low throughout.
REQ-035 Backpressure: out_ready low 3 cycles after out_valid -> result/flags stable, in_ready low; out_ready high -> IDLE next cycle, in_ready high.
REQ-036 Reset asserted 4 cycles into MUL -> next cycle IDLE, out_valid 0, all outputs 0, in_ready 1 after deassert.
